// File: rtl/adder_seq_if.sv
// Handshake and operand/result bundle for adder_seq.
// Optional feature macro: ADDER_SEQ_CIN_EN (adds cin_ext).
interface adder_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             op_add;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ADDER_SEQ_CIN_EN
    logic             cin_ext;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             sign;
    logic             zero;

    modport master (
        output in_valid, op_add, a, b,
`ifdef ADDER_SEQ_CIN_EN
        output cin_ext,
`endif
        output out_ready,
        input  in_ready, out_valid, result, carry, overflow, sign, zero
    );

    modport slave (
        input  in_valid, op_add, a, b,
`ifdef ADDER_SEQ_CIN_EN
        input  cin_ext,
`endif
        input  out_ready,
        output in_ready, out_valid, result, carry, overflow, sign, zero
    );
endinterface

// File: rtl/adder_seq.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered ripple carry.
// Optional feature macro: ADDER_SEQ_CIN_EN (external carry/borrow-in on cin_ext).
module adder_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic        clk,
    input  logic        rst,
    adder_seq_if.slave  bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             op_add_r;
    logic             chunk_carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;
    logic             sign_r;
    logic             zero_r;

    logic             accept_s;
    logic             last_s;
    logic             seed_s;
    logic [CHUNK:0]   sum_s;
    logic [WIDTH-1:0] result_s;

    assign accept_s = (state_r == IDLE) && bus.in_valid;
    assign last_s   = (cnt_r == CW'(N - 1));

    // Carry seed: subtraction is a + ~b + 1, with an optional borrow-in removing the +1.
    always_comb begin
`ifdef ADDER_SEQ_CIN_EN
        seed_s = bus.op_add ? bus.cin_ext : ~bus.cin_ext;
`else
        seed_s = ~bus.op_add;
`endif
    end

    // One chunk of the ripple add, merged into the partial result.
    always_comb begin
        sum_s    = {1'b0, a_r[int'(cnt_r) * CHUNK +: CHUNK]}
                 + {1'b0, b_r[int'(cnt_r) * CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, chunk_carry_r};
        result_s = result_r;
        result_s[int'(cnt_r) * CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Operand latch, chunk datapath and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            op_add_r      <= 1'b0;
            chunk_carry_r <= 1'b0;
            cnt_r         <= {CW{1'b0}};
            result_r      <= {WIDTH{1'b0}};
            carry_r       <= 1'b0;
            overflow_r    <= 1'b0;
            sign_r        <= 1'b0;
            zero_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r           <= bus.a;
                        b_r           <= bus.op_add ? bus.b : ~bus.b;
                        op_add_r      <= bus.op_add;
                        chunk_carry_r <= seed_s;
                        cnt_r         <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    result_r      <= result_s;
                    chunk_carry_r <= sum_s[CHUNK];
                    cnt_r         <= cnt_r + CW'(1);
                    if (last_s) begin
                        // b_r already holds ~b for subtract, so one overflow rule serves both ops.
                        carry_r    <= op_add_r ? sum_s[CHUNK] : ~sum_s[CHUNK];
                        overflow_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                      (result_s[WIDTH-1] != a_r[WIDTH-1]);
                        sign_r     <= result_s[WIDTH-1];
                        zero_r     <= (result_s == {WIDTH{1'b0}});
                    end
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.out_valid = (state_r == DONE);
    assign bus.result    = result_r;
    assign bus.carry     = carry_r;
    assign bus.overflow  = overflow_r;
    assign bus.sign      = sign_r;
    assign bus.zero      = zero_r;
endmodule

// File: tb/tb_adder_seq.sv
// Randomised and directed bench for adder_seq against an arithmetic reference model.
module tb_adder_seq;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    adder_seq_if #(.WIDTH(WIDTH)) bus_if ();

    adder_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {result, carry, overflow, sign, zero} from whole-word arithmetic.
    function automatic logic [WIDTH+3:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic op_add, input logic cin);
        logic [WIDTH:0] full;
        longint         sr;
        longint         smax;
        longint         smin;
        logic           ovf;
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        if (op_add) begin
            full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            sr   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        end else begin
            full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            sr   = longint'($signed(a)) - longint'($signed(b)) - longint'(cin);
        end
        ovf = (sr > smax) || (sr < smin);
        return {full[WIDTH-1:0], full[WIDTH], ovf, full[WIDTH-1], full[WIDTH-1:0] == {WIDTH{1'b0}}};
    endfunction

    task automatic drive_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic op_add, input logic cin);
        bus_if.a      = a;
        bus_if.b      = b;
        bus_if.op_add = op_add;
`ifdef ADDER_SEQ_CIN_EN
        bus_if.cin_ext = cin;
`else
        if (cin) $display("note: cin ignored without ADDER_SEQ_CIN_EN");
        else     bus_if.op_add = op_add;
`endif
    endtask

    // One operation: accept, check latency and results, then drain with out_ready.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic op_add, input logic cin, input string tag);
        logic [WIDTH+3:0] exp;
        logic [WIDTH+3:0] got;
        int               lat;
        int               guard;
        exp   = model(a, b, op_add, cin);
        guard = 0;
        while (!bus_if.in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        drive_ops(a, b, op_add, cin);
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        drive_ops($urandom, $urandom, 1'($urandom), 1'b0);
        lat = 0;
        while (!bus_if.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (lat !== N) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, N);
        end
        got = {bus_if.result, bus_if.carry, bus_if.overflow, bus_if.sign, bus_if.zero};
        total++;
        if (got[WIDTH+3:4] !== exp[WIDTH+3:4]) begin
            bad++;
            $display("FAIL %s result: got %h want %h", tag, got[WIDTH+3:4], exp[WIDTH+3:4]);
        end
        total++;
        if (got[3:0] !== exp[3:0]) begin
            bad++;
            $display("FAIL %s flags(c,v,s,z): got %b want %b", tag, got[3:0], exp[3:0]);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        total++;
        if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s drain: got rdy=%b vld=%b want rdy=1 vld=0", tag, bus_if.in_ready, bus_if.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({bus_if.in_ready, bus_if.out_valid, bus_if.result, bus_if.carry, bus_if.overflow,
             bus_if.sign, bus_if.zero} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 4'b0000}) begin
            bad++;
            $display("FAIL reset state: got rdy=%b vld=%b res=%h flags=%b want rdy=1 vld=0 res=0 flags=0",
                     bus_if.in_ready, bus_if.out_valid, bus_if.result,
                     {bus_if.carry, bus_if.overflow, bus_if.sign, bus_if.zero});
        end
    endtask

    task automatic test_directed();
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, "add_ovf");
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, "add_ripple");
        run_op(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, "sub_zero");
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, "sub_borrow");
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, "sub_ovf");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic             cin;
            a = $urandom;
            b = (i % 5 == 0) ? a : $urandom;
`ifdef ADDER_SEQ_CIN_EN
            cin = 1'($urandom);
`else
            cin = 1'b0;
`endif
            run_op(a, b, 1'($urandom), cin, "random");
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH+3:0] exp;
        logic [WIDTH+3:0] got;
        int               guard;
        exp = model(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
        drive_ops(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0);
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        guard = 0;
        while (!bus_if.out_valid && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                drive_ops(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0);
                bus_if.in_valid = 1'b1;
            end else begin
                bus_if.in_valid = 1'b0;
            end
            got = {bus_if.result, bus_if.carry, bus_if.overflow, bus_if.sign, bus_if.zero};
            total++;
            if (got !== exp || bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure hold cycle %0d: got %h vld=%b rdy=%b want %h vld=1 rdy=0",
                         i, got, bus_if.out_valid, bus_if.in_ready, exp);
            end
            @(posedge clk); #1;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure release: got rdy=%b vld=%b want rdy=1 vld=0",
                     bus_if.in_ready, bus_if.out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        drive_ops(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 1'b0);
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({bus_if.in_ready, bus_if.out_valid, bus_if.result, bus_if.carry, bus_if.overflow,
             bus_if.sign, bus_if.zero} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 4'b0000}) begin
            bad++;
            $display("FAIL mid_run_reset: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0 flags=0",
                     bus_if.in_ready, bus_if.out_valid, bus_if.result);
        end
        run_op(32'd3, 32'd4, 1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_cin();
`ifdef ADDER_SEQ_CIN_EN
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, "cin_add");
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, "cin_sub");
`else
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, "zero_add");
`endif
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        drive_ops({WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_cin();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
